// File: rtl/otfc_pkg.sv
// Shared types for the on-the-fly quotient converter.
// Digit encodings and FSM state encoding.
package otfc_pkg;

    localparam logic [1:0] DIG_POS  = 2'b10;
    localparam logic [1:0] DIG_ZERO = 2'b00;
    localparam logic [1:0] DIG_NEG  = 2'b01;
    localparam logic [1:0] DIG_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CONVERT = 2'b01,
        DONE    = 2'b10
    } state_t;

endpackage

// File: rtl/otfc_digit_update.sv
// Next-state logic for the Q/QM register pair.
// Illegal digit 2'b11 is treated as zero and flagged.
module otfc_digit_update
    import otfc_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] qm,
    input  logic [1:0]   digit,
    output logic [W-1:0] q_next,
    output logic [W-1:0] qm_next,
    output logic         illegal
);

    always_comb begin
        q_next  = {q[W-2:0], 1'b0};
        qm_next = {qm[W-2:0], 1'b1};
        illegal = 1'b0;
        unique case (digit)
            DIG_POS: begin
                q_next  = {q[W-2:0], 1'b1};
                qm_next = {q[W-2:0], 1'b0};
            end
            DIG_NEG: begin
                q_next  = {qm[W-2:0], 1'b1};
                qm_next = {qm[W-2:0], 1'b0};
            end
            DIG_ZERO: begin
                q_next  = {q[W-2:0], 1'b0};
                qm_next = {qm[W-2:0], 1'b1};
            end
            DIG_ILL: begin
                q_next  = {q[W-2:0], 1'b0};
                qm_next = {qm[W-2:0], 1'b1};
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/on_the_fly_converter.sv
// Serial signed-digit quotient to two's-complement converter.
// Define OTFC_FLOOR_EN to add a guard digit giving floor truncation.
module on_the_fly_converter
    import otfc_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int CNT_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                digit_valid,
    input  logic [1:0]          q_digit,
    output logic                busy,
    output logic                done,
    output logic                result_valid,
    output logic [N_DIGITS:0]   result,
    output logic [CNT_W-1:0]    digit_cnt,
    output logic                err_digit
);

    localparam int W = N_DIGITS + 1;
`ifdef OTFC_FLOOR_EN
    localparam int TARGET = N_DIGITS + 1;
`else
    localparam int TARGET = N_DIGITS;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TARGET - 1);
    localparam logic [W-1:0]     ONE_W    = W'(1);

    state_t       state;
    logic [W-1:0] q_r;
    logic [W-1:0] qm_r;
    logic [W-1:0] q_nx;
    logic [W-1:0] qm_nx;
    logic [W-1:0] final_val;
    logic         ill;
    logic         accept;
    logic         last;
    logic         shift_en;

    otfc_digit_update #(
        .W(W)
    ) u_upd (
        .q       (q_r),
        .qm      (qm_r),
        .digit   (q_digit),
        .q_next  (q_nx),
        .qm_next (qm_nx),
        .illegal (ill)
    );

    // start always wins over a coincident digit
    assign accept = (state == CONVERT) && digit_valid && !start;
    assign last   = accept && (digit_cnt == LAST_CNT);

`ifdef OTFC_FLOOR_EN
    // guard digit selects Q or QM without shifting
    assign shift_en  = accept &&
                       (digit_cnt != CNT_W'(N_DIGITS));
    assign final_val = (q_digit == DIG_NEG) ? qm_r : q_r;
`else
    assign shift_en  = accept;
    assign final_val = q_nx;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            q_r          <= '0;
            qm_r         <= '1;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            digit_cnt    <= '0;
            err_digit    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state        <= CONVERT;
                q_r          <= '0;
                qm_r         <= '1;
                digit_cnt    <= '0;
                err_digit    <= 1'b0;
                result_valid <= 1'b0;
                busy         <= 1'b1;
            end else if (accept) begin
                digit_cnt <= digit_cnt + 1'b1;
                if (ill) begin
                    err_digit <= 1'b1;
                end
                if (shift_en) begin
                    q_r  <= q_nx;
                    qm_r <= qm_nx;
                end
                if (last) begin
                    state        <= DONE;
                    result       <= final_val;
                    done         <= 1'b1;
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                end
            end
        end
    end

    // QM must always trail Q by exactly one ulp
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (qm_r == q_r - ONE_W);
        end
    end

endmodule

// File: tb/tb_on_the_fly_converter.sv
// Scoreboard bench for on_the_fly_converter (N_DIGITS=4).
// Expected results come from an arithmetic digit-sum model.
module tb_on_the_fly_converter;

    localparam int N  = 4;
    localparam int CW = 5;
    localparam int W  = N + 1;
`ifdef OTFC_FLOOR_EN
    localparam int TGT = N + 1;
`else
    localparam int TGT = N;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          digit_valid = 1'b0;
    logic [1:0]    q_digit = 2'b00;
    logic          busy;
    logic          done;
    logic          result_valid;
    logic [W-1:0]  result;
    logic [CW-1:0] digit_cnt;
    logic          err_digit;

    on_the_fly_converter #(
        .N_DIGITS (N),
        .CNT_W    (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .digit_valid  (digit_valid),
        .q_digit      (q_digit),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid),
        .result       (result),
        .digit_cnt    (digit_cnt),
        .err_digit    (err_digit)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] hold_m = '0;
    logic [W-1:0] popped;
    int  acc   = 0;
    int  cnt_m = 0;
    bit  active = 0;
    bit  gneg   = 0;
    bit  pend   = 0;
    bit  post   = 0;
    bit  busy_m = 0;
    bit  rv_m   = 0;
    bit  err_m  = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int dval(logic [1:0] d);
        case (d)
            2'b10:   return 1;
            2'b01:   return -1;
            default: return 0;
        endcase
    endfunction

    task automatic drive(bit s, bit v, logic [1:0] d);
        @(negedge clk);
        chk("digit_cnt", 32'(digit_cnt), 32'(cnt_m));
        chk("busy", 32'(busy), 32'(busy_m));
        chk("result_valid", 32'(result_valid), 32'(rv_m));
        chk("err_digit", 32'(err_digit), 32'(err_m));
        if (rv_m) chk("result_hold", 32'(result), 32'(hold_m));
        if (pend) begin
            chk("done_latency", 32'(done), 32'(1));
            pend = 0;
            post = 1;
        end else if (post) begin
            chk("done_pulse", 32'(done), 32'(0));
            post = 0;
        end
        start       = s;
        digit_valid = v;
        q_digit     = d;
        if (s) begin
            active = 1; cnt_m = 0; acc = 0; gneg = 0;
            busy_m = 1; rv_m = 0; err_m = 0;
        end else if (v && active) begin
            if (cnt_m < N) acc = acc * 2 + dval(d);
            else gneg = (d == 2'b01);
            if (d == 2'b11) err_m = 1;
            cnt_m++;
            if (cnt_m == TGT) begin
                hold_m = W'(acc - int'(gneg));
                exp_q.push_back(hold_m);
                active = 0; pend = 1; busy_m = 0; rv_m = 1;
            end
        end
    endtask

    task automatic idle(); drive(0, 0, 2'b00); endtask
    task automatic go();   drive(1, 0, 2'b00); endtask
    task automatic dg(logic [1:0] d); drive(0, 1, d); endtask

    task automatic fin(logic [1:0] g);
`ifdef OTFC_FLOOR_EN
        dg(g);
`else
        if (g == 2'b11) $display("note: unused guard");
`endif
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'(done), 32'(0));
            end else begin
                popped = exp_q.pop_front();
                chk("result", 32'(result), 32'(popped));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_rv", 32'(result_valid), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_cnt", 32'(digit_cnt), 32'(0));
        chk("rst_err", 32'(err_digit), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        // digits ignored while idle
        dg(2'b10); idle();

        go(); dg(2'b10); dg(2'b00); dg(2'b01); dg(2'b10); fin(2'b00);
        dg(2'b10); dg(2'b01); idle(); idle();

        go(); dg(2'b01); dg(2'b01); dg(2'b01); dg(2'b01); fin(2'b00);
        idle(); idle();
        go(); dg(2'b10); dg(2'b10); dg(2'b10); dg(2'b10); fin(2'b10);
        idle(); idle();

        go(); dg(2'b10); idle(); idle(); dg(2'b00); dg(2'b00); dg(2'b00);
        fin(2'b00); idle(); idle();

        go(); dg(2'b10); dg(2'b10); drive(1, 1, 2'b10);
        dg(2'b00); dg(2'b00); dg(2'b00); dg(2'b01); fin(2'b00);
        idle(); idle();

        go(); dg(2'b10); dg(2'b11); dg(2'b00); dg(2'b00); fin(2'b00);
        idle(); idle(); idle();

        go(); dg(2'b10); dg(2'b00);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_done", 32'(done), 32'(0));
        chk("arst_rv", 32'(result_valid), 32'(0));
        chk("arst_result", 32'(result), 32'(0));
        chk("arst_cnt", 32'(digit_cnt), 32'(0));
        chk("arst_err", 32'(err_digit), 32'(0));
        active = 0; cnt_m = 0; acc = 0; gneg = 0;
        pend = 0; post = 0; busy_m = 0; rv_m = 0; err_m = 0;
        start = 1'b0; digit_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        dg(2'b10); dg(2'b10); idle();

`ifdef OTFC_FLOOR_EN
        go(); dg(2'b10); dg(2'b00); dg(2'b00); dg(2'b00); dg(2'b01);
        idle(); idle();
        go(); dg(2'b10); dg(2'b00); dg(2'b00); dg(2'b00); dg(2'b00);
        idle(); idle();
        go(); dg(2'b10); dg(2'b00); dg(2'b00); dg(2'b00); dg(2'b10);
        idle(); idle();
`endif

        idle(); idle();
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/on_the_fly_converter.md
Name: on_the_fly_converter

Overview:
- Sits directly downstream of the on-line divider. Consumes its serial radix-2 signed-digit quotient stream (q_value), one digit per cycle, MSD first.
- Performs on-the-fly conversion (Q/QM register pair) to a conventional two's-complement fractional result, with no carry-propagate adder.
- The result is available one cycle after the last digit is accepted, so conversion is fully overlapped with the divider.

Parameters:
- N_DIGITS, 8: quotient digits per operation; result is N_DIGITS+1 bits wide, i.e. the value scaled by 2^N_DIGITS.
- CNT_W, 5: width of digit counter; must satisfy 2^CNT_W > N_DIGITS+1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; clears Q/QM and begins a new conversion.
- digit_valid  in  1  q_digit is a valid quotient digit this cycle.
- q_digit  in  2  signed digit from divider; [1]=plus bit, [0]=minus bit; value = plus - minus.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when the result becomes final.
- result_valid  out  1  level; result is final and held.
- result  out  N_DIGITS+1  two's-complement converted quotient.
- digit_cnt  out  CNT_W  digits accepted in the current operation.
- err_digit  out  1  sticky; an illegal digit 2'b11 was received.

Behaviour:
- Reset (async, rst=1): FSM=IDLE, Q=0, QM=all ones, busy=0, done=0, result_valid=0, result=0, digit_cnt=0, err_digit=0.
- FSM states:
  - IDLE: start -> CONVERT.
  - CONVERT: after the last digit is accepted -> DONE.
  - DONE: start -> CONVERT.
- On start: Q<=0, QM<=all ones (-1), digit_cnt<=0, err_digit<=0, result_valid<=0, busy<=1.
- start in any state, including mid-CONVERT, aborts and restarts. If start and digit_valid arrive in the same cycle, start wins and the digit is dropped.
- In CONVERT, each cycle with digit_valid=1 updates Q and QM by shift-and-append:
  - q=+1: Q<={Q,1}, QM<={Q,0}.
  - q=0: Q<={Q,0}, QM<={QM,1}.
  - q=-1: Q<={QM,1}, QM<={QM,0}.
  - The shift drops the MSB; registers stay N_DIGITS+1 bits.
- Digit encoding 2'b11 is treated as 0 and sets err_digit; err_digit stays set until the next start or rst.
- digit_valid=0 in CONVERT: Q, QM and digit_cnt hold; digit bubbles are allowed.
- digit_valid is ignored in IDLE and DONE.
- Completion: the cycle the final digit is accepted, digit_cnt reaches the target.
  - Next cycle: result is registered, done pulses for 1 cycle, result_valid=1, busy=0, state=DONE.
  - Latency from last digit to done is 1 cycle.
- result holds until the next start. result_valid drops in the cycle after start.
- Invariant QM = Q - 1 (mod 2^(N_DIGITS+1)) holds after every update; this is a verification assertion.
- Range: a digit string in (-1,1) always fits; no overflow detection.

Optional Feature:
- Macro OTFC_FLOOR_EN.
- Defined:
  - The converter accepts N_DIGITS+1 digits; the extra digit is a guard digit.
  - Final result = QM_N if the guard digit is -1, else Q_N, where Q_N/QM_N are the registers after N_DIGITS digits.
  - This gives floor truncation of the exact quotient.
  - The guard digit does not shift Q/QM.
- Undefined: exactly N_DIGITS digits are accepted; result = Q_N (exact truncation of the digit string).

Decomposition:
- Package otfc_pkg holds:
  - digit encoding constants DIG_POS=2'b10, DIG_ZERO=2'b00, DIG_NEG=2'b01, DIG_ILL=2'b11;
  - the state encoding IDLE/CONVERT/DONE.
- One natural sub-module, otfc_digit_update: combinational next-Q/next-QM from (Q, QM, digit), plus the illegal-digit flag. The FSM, counter and result register stay in the top.

Test Plan (N_DIGITS=4, result 5 bits):
- start; digits +1,0,-1,+1 -> done pulses 1 cycle after 4th digit; result=5'b00111 (7/16); err_digit=0.
- start; digits -1,-1,-1,-1 -> result=5'b10001 (-15); then +1 x4 after new start -> result=5'b01111.
- start; digits +1,bubble,bubble,0,0,0 (digit_valid low 2 cycles) -> result=5'b01000; digit_cnt holds during bubbles.
- start; +1,+1, then start with digit_valid=1, q=+1 same cycle, then 0,0,0,-1 -> digit dropped; result=5'b11111 (-1); rst asserted mid-CONVERT -> all outputs to reset values immediately.
- start; digits +1,11,0,0 -> treated as 0: result=5'b01000, err_digit=1 until next start.
- OTFC_FLOOR_EN: digits +1,0,0,0, guard -1 -> result=5'b00111; guard 0 or +1 -> result=5'b01000.
